// File: rtl/ex_div.sv
// rtl/ex_div.sv - 32-bit signed/unsigned restoring radix-2 divider for the EX stage
// One quotient bit per cycle; the result is registered on the way out of END.
module ex_div (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o,
    output logic        busy_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BY_ZERO,
        S_ON,
        S_END
    } state_t;

    state_t      state, state_next;
    logic [5:0]  cnt;
    logic [64:0] dividend;
    logic [31:0] divisor;
    logic        neg_quo;
    logic        neg_rem;
    logic [63:0] res;

    logic [31:0] mag1, mag2;
    logic [64:0] shifted;
    logic [33:0] trial;
    logic [64:0] step;
    logic [31:0] quo_fix, rem_fix;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (annul_i) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        state_next = (opdata2_i == 32'd0) ? S_BY_ZERO : S_ON;
                    end
                end
                S_BY_ZERO: state_next = S_END;
                S_ON: begin
                    if (cnt == 6'd31) begin
                        state_next = S_END;
                    end
                end
                S_END: begin
                    if (!start_i) begin
                        state_next = S_IDLE;
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    // Operand magnitudes; 0x80000000 negates to itself, which is the right unsigned magnitude.
    always_comb begin
        mag1 = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
        mag2 = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;
    end

    // The trial subtract uses the full 33-bit partial remainder so divisors above 2^31 work.
    always_comb begin
        shifted = {dividend[63:0], 1'b0};
        trial   = {1'b0, shifted[64:32]} - {2'b00, divisor};
        step    = shifted;
        if (!trial[33]) begin
            step[64:32] = trial[32:0];
            step[0]     = 1'b1;
        end
        quo_fix = neg_quo ? (~step[31:0] + 32'd1) : step[31:0];
        rem_fix = neg_rem ? (~step[63:32] + 32'd1) : step[63:32];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= 6'd0;
            dividend <= 65'd0;
            divisor  <= 32'd0;
            neg_quo  <= 1'b0;
            neg_rem  <= 1'b0;
            res      <= 64'd0;
            result_o <= 64'd0;
            ready_o  <= 1'b0;
        end else if (annul_i) begin
            cnt      <= 6'd0;
            result_o <= 64'd0;
            ready_o  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    result_o <= 64'd0;
                    ready_o  <= 1'b0;
                    if (start_i) begin
                        cnt      <= 6'd0;
                        dividend <= {33'd0, mag1};
                        divisor  <= mag2;
                        neg_quo  <= signed_div_i && (opdata1_i[31] ^ opdata2_i[31]);
                        neg_rem  <= signed_div_i && opdata1_i[31];
                    end
                end
                S_BY_ZERO: begin
                    res <= 64'd0;
                end
                S_ON: begin
                    dividend <= step;
                    cnt      <= cnt + 6'd1;
                    if (cnt == 6'd31) begin
                        res <= {rem_fix, quo_fix};
                    end
                end
                S_END: begin
                    if (start_i) begin
                        result_o <= res;
                        ready_o  <= 1'b1;
                    end else begin
                        result_o <= 64'd0;
                        ready_o  <= 1'b0;
                    end
                end
                default: begin
                    result_o <= 64'd0;
                    ready_o  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o = (state == S_BY_ZERO) || (state == S_ON);

endmodule

// File: tb/tb_ex_div.sv
// tb/tb_ex_div.sv - self-checking bench for ex_div against an arithmetic reference
// Directed corner cases, annul/reset interruption, then randomized operands.
module tb_ex_div;

    logic        clk;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        busy_o;

    int checks = 0;
    int errors = 0;

    ex_div dut (
        .clk         (clk),
        .rst         (rst),
        .signed_div_i(signed_div_i),
        .opdata1_i   (opdata1_i),
        .opdata2_i   (opdata2_i),
        .start_i     (start_i),
        .annul_i     (annul_i),
        .result_o    (result_o),
        .ready_o     (ready_o),
        .busy_o      (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [31:0] uq, ur;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            return {r[31:0], q[31:0]};
        end
        uq = a / b;
        ur = a % b;
        return {ur, uq};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Caller has set inputs at a negedge with start_i high; the next posedge is edge N.
    task automatic watch(input string tag, input logic [63:0] exp, input int exp_lat, input int exp_busy);
        int k = 0;
        int nbusy = 0;
        logic leak = 1'b0;
        logic [63:0] held;
        @(posedge clk);
        while (k < 60) begin
            @(negedge clk);
            if (ready_o) break;
            if (result_o !== 64'd0) leak = 1'b1;
            if (busy_o) nbusy++;
            opdata1_i    = $urandom;
            opdata2_i    = $urandom;
            signed_div_i = 1'($urandom);
            k++;
            @(posedge clk);
        end
        check({tag, " result"}, result_o, exp);
        check({tag, " latency"}, 64'(k), 64'(exp_lat));
        check({tag, " busy"}, 64'(nbusy), 64'(exp_busy));
        check({tag, " zero_while_not_ready"}, 64'(leak), 64'd0);
        held = result_o;
        @(negedge clk);
        check({tag, " end_hold"}, {result_o[62:0], ready_o}, {held[62:0], 1'b1});
        start_i = 1'b0;
        @(negedge clk);
        check({tag, " release"}, {result_o[62:0], ready_o}, 64'd0);
    endtask

    task automatic do_div(input string tag, input logic sgn, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        watch(tag, ref_div(sgn, a, b), (b == 32'd0) ? 2 : 33, (b == 32'd0) ? 1 : 32);
    endtask

    initial begin
        logic        seen_ready;
        logic        sgn;
        logic [31:0] a, b;
        rst          = 1'b1;
        signed_div_i = 1'b0;
        opdata1_i    = 32'd0;
        opdata2_i    = 32'd0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {result_o[61:0], ready_o, busy_o}, 64'd0);
        rst = 1'b0;

        do_div("u100_7", 1'b0, 32'd100, 32'd7);
        check("u100_7 literal", ref_div(1'b0, 32'd100, 32'd7), {32'd2, 32'd14});
        do_div("s-7_2", 1'b1, 32'hFFFFFFF9, 32'd2);
        do_div("s7_-2", 1'b1, 32'd7, 32'hFFFFFFFE);
        do_div("div0", 1'b0, 32'h12345678, 32'd0);
        do_div("s_min_-1", 1'b1, 32'h80000000, 32'hFFFFFFFF);
        do_div("u_min_-1", 1'b0, 32'h80000000, 32'hFFFFFFFF);
        do_div("u_max_1", 1'b0, 32'hFFFFFFFF, 32'd1);
        do_div("s_div0", 1'b1, 32'h80000001, 32'd0);

        // Annul mid-operation with start held
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = 32'd1000;
        opdata2_i    = 32'd3;
        start_i      = 1'b1;
        seen_ready   = 1'b0;
        @(posedge clk);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (ready_o) seen_ready = 1'b1;
        end
        @(negedge clk);
        annul_i = 1'b1;
        @(negedge clk);
        check("annul_idle", {result_o[61:0], ready_o, busy_o}, 64'd0);
        annul_i = 1'b0;
        start_i = 1'b0;
        @(negedge clk);
        if (ready_o) seen_ready = 1'b1;
        check("annul_no_ready", 64'(seen_ready), 64'd0);
        do_div("after_annul", 1'b0, 32'd50, 32'd5);

        // Reset mid-operation, start held through and after release
        @(negedge clk);
        signed_div_i = 1'b1;
        opdata1_i    = 32'hFFFF0000;
        opdata2_i    = 32'd9;
        start_i      = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 20; k++) @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid", {result_o[61:0], ready_o, busy_o}, 64'd0);
        rst          = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = 32'd77777;
        opdata2_i    = 32'd123;
        watch("after_rst", ref_div(1'b0, 32'd77777, 32'd123), 33, 32);

        for (int i = 0; i < 16; i++) begin
            sgn = 1'($urandom);
            a   = $urandom;
            case ($urandom_range(0, 3))
                0: b = 32'd0;
                1: b = $urandom_range(1, 15);
                2: b = 32'hFFFFFFFF - $urandom_range(0, 3);
                default: b = $urandom;
            endcase
            do_div($sformatf("rand%0d", i), sgn, a, b);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
